// File: rtl/ex_alu_cond_unit_if.sv
// Execute-stage operand/control bundle for ex_alu_cond_unit.
// The master side (ID/EX register) drives operands; the slave side (the unit) returns results.
interface ex_alu_cond_unit_if;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic        s_bit;
  logic        shifter_carry;
  logic [3:0]  cond;
  logic        b_instr;
  logic        bl_instr;
  logic [31:0] pc_in;
  logic [23:0] imm24;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  flags;
  logic        cond_true;
  logic        no_write;
  logic        branch_taken;
  logic        link_write;
  logic [31:0] branch_target;

  modport master (
    output alu_a, alu_b, alu_op, s_bit, shifter_carry, cond,
           b_instr, bl_instr, pc_in, imm24,
    input  alu_out, alu_flags, flags, cond_true, no_write,
           branch_taken, link_write, branch_target
  );

  modport slave (
    input  alu_a, alu_b, alu_op, s_bit, shifter_carry, cond,
           b_instr, bl_instr, pc_in, imm24,
    output alu_out, alu_flags, flags, cond_true, no_write,
           branch_taken, link_write, branch_target
  );
endinterface

// File: rtl/ex_alu_cond_unit.sv
// Execute-stage slice: 16-op ALU with NZCV, branch-target adder and condition check.
// The registered NZCV is the only state; everything else is combinational.
module ex_alu_cond_unit (
  input  logic              CLK,
  input  logic              CLR,
  ex_alu_cond_unit_if.slave bus
);

  logic [3:0]  flags_q;
  logic [3:0]  flags_d;
  logic [31:0] add_x;
  logic [31:0] add_y;
  logic        add_cin;
  logic        is_arith;
  logic [32:0] add_sum;
  logic [31:0] result;
  logic        c_out;
  logic        v_out;
  logic        cond_pass;
  logic        n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Every arithmetic opcode maps onto one adder; subtraction is x + ~y + cin.
  always_comb begin
    add_x    = bus.alu_a;
    add_y    = bus.alu_b;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (bus.alu_op)
      4'd2, 4'd10: begin add_y = ~bus.alu_b; add_cin = 1'b1; end
      4'd3:        begin add_x = bus.alu_b; add_y = ~bus.alu_a; add_cin = 1'b1; end
      4'd4, 4'd11: add_cin = 1'b0;
      4'd5:        add_cin = c_f;
      4'd6:        begin add_y = ~bus.alu_b; add_cin = c_f; end
      4'd7:        begin add_x = bus.alu_b; add_y = ~bus.alu_a; add_cin = c_f; end
      default:     is_arith = 1'b0;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

  always_comb begin
    result = add_sum[31:0];
    case (bus.alu_op)
      4'd0, 4'd8: result = bus.alu_a & bus.alu_b;
      4'd1, 4'd9: result = bus.alu_a ^ bus.alu_b;
      4'd12:      result = bus.alu_a | bus.alu_b;
      4'd13:      result = bus.alu_b;
      4'd14:      result = bus.alu_a & ~bus.alu_b;
      4'd15:      result = ~bus.alu_b;
      default:    result = add_sum[31:0];
    endcase
  end

  // Logical ops take C from the shifter and leave V as it was.
  assign c_out = is_arith ? add_sum[32] : bus.shifter_carry;
  assign v_out = is_arith ? ((add_x[31] == add_y[31]) && (add_sum[31] != add_x[31])) : v_f;

  always_comb begin
    cond_pass = 1'b0;
    case (bus.cond)
      4'd0:    cond_pass = z_f;
      4'd1:    cond_pass = ~z_f;
      4'd2:    cond_pass = c_f;
      4'd3:    cond_pass = ~c_f;
      4'd4:    cond_pass = n_f;
      4'd5:    cond_pass = ~n_f;
      4'd6:    cond_pass = v_f;
      4'd7:    cond_pass = ~v_f;
      4'd8:    cond_pass = c_f & ~z_f;
      4'd9:    cond_pass = ~c_f | z_f;
      4'd10:   cond_pass = (n_f == v_f);
      4'd11:   cond_pass = (n_f != v_f);
      4'd12:   cond_pass = ~z_f & (n_f == v_f);
      4'd13:   cond_pass = z_f | (n_f != v_f);
      4'd14:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (bus.s_bit && cond_pass) begin
      flags_d = bus.alu_flags;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.alu_out       = result;
  assign bus.alu_flags     = {result[31], (result == 32'd0), c_out, v_out};
  assign bus.flags         = flags_q;
  assign bus.cond_true     = cond_pass;
  assign bus.no_write      = (bus.alu_op[3:2] == 2'b10);
  assign bus.branch_taken  = (bus.b_instr | bus.bl_instr) & cond_pass;
  assign bus.link_write    = bus.bl_instr & cond_pass;
  assign bus.branch_target = bus.pc_in + {{6{bus.imm24[23]}}, bus.imm24, 2'b00};

endmodule

// File: tb/tb_ex_alu_cond_unit.sv
// Scoreboard bench for ex_alu_cond_unit: a behavioural model pushes expectations,
// which are popped and compared once the DUT outputs settle.
module tb_ex_alu_cond_unit;

  logic clk;
  logic clr;
  ex_alu_cond_unit_if bus ();

  ex_alu_cond_unit dut (
    .CLK(clk),
    .CLR(clr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [3:0]  af;
    logic        ct;
    logic        nw;
    logic        bt;
    logic        lw;
    logic [31:0] tgt;
    logic [3:0]  fl_after;
  } exp_t;

  exp_t sb_q[$];
  int checks;
  int failures;
  logic [3:0] model_flags;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_model(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Wide signed/unsigned arithmetic gives C and V without reusing the adder trick.
  task automatic alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic sc, input logic [3:0] f,
                           output logic [31:0] res, output logic [3:0] af);
    longint unsigned ua, ub, full;
    longint sa, sb, sfull;
    logic c, v, cin, nb;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    cin = f[1]; nb = !f[1];
    c = sc; v = f[0]; full = 0; sfull = 0; res = 0;
    case (op)
      4'd0, 4'd8: res = a & b;
      4'd1, 4'd9: res = a ^ b;
      4'd12: res = a | b;
      4'd13: res = b;
      4'd14: res = a & ~b;
      4'd15: res = ~b;
      4'd4, 4'd11: begin full = ua + ub; c = full[32]; sfull = sa + sb; end
      4'd5: begin full = ua + ub + cin; c = full[32]; sfull = sa + sb + cin; end
      4'd2, 4'd10: begin full = ua - ub; c = ua >= ub; sfull = sa - sb; end
      4'd3: begin full = ub - ua; c = ub >= ua; sfull = sb - sa; end
      4'd6: begin full = ua - ub - nb; c = ua >= ub + nb; sfull = sa - sb - nb; end
      default: begin full = ub - ua - nb; c = ub >= ua + nb; sfull = sb - sa - nb; end
    endcase
    if (!(op inside {4'd0, 4'd1, 4'd8, 4'd9, 4'd12, 4'd13, 4'd14, 4'd15})) begin
      res = full[31:0];
      v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
    end
    af = {res[31], res == 32'd0, c, v};
  endtask

  task automatic do_txn(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic s, input logic sc,
                        input logic [3:0] cc, input logic bi, input logic bli,
                        input logic [31:0] pc, input logic [23:0] imm, input logic rst);
    exp_t e, got;
    int off;
    @(negedge clk);
    bus.alu_op = op; bus.alu_a = a; bus.alu_b = b; bus.s_bit = s;
    bus.shifter_carry = sc; bus.cond = cc; bus.b_instr = bi; bus.bl_instr = bli;
    bus.pc_in = pc; bus.imm24 = imm; clr = rst;
    e.tag = tag;
    alu_model(op, a, b, sc, model_flags, e.res, e.af);
    e.ct  = cond_model(cc, model_flags);
    e.nw  = (op >= 4'd8) && (op <= 4'd11);
    e.bt  = (bi || bli) && e.ct;
    e.lw  = bli && e.ct;
    off   = $signed(imm);
    e.tgt = pc + 32'(off * 4);
    if (rst) e.fl_after = 4'b0000;
    else if (s && e.ct) e.fl_after = e.af;
    else e.fl_after = model_flags;
    sb_q.push_back(e);
    #2;
    got = sb_q.pop_front();
    check_eq({got.tag, ".alu_out"}, bus.alu_out, got.res);
    check_eq({got.tag, ".alu_flags"}, 32'(bus.alu_flags), 32'(got.af));
    check_eq({got.tag, ".cond_true"}, 32'(bus.cond_true), 32'(got.ct));
    check_eq({got.tag, ".no_write"}, 32'(bus.no_write), 32'(got.nw));
    check_eq({got.tag, ".branch_taken"}, 32'(bus.branch_taken), 32'(got.bt));
    check_eq({got.tag, ".link_write"}, 32'(bus.link_write), 32'(got.lw));
    check_eq({got.tag, ".branch_target"}, bus.branch_target, got.tgt);
    @(posedge clk);
    #1;
    model_flags = got.fl_after;
    check_eq({got.tag, ".flags"}, 32'(bus.flags), 32'(got.fl_after));
    clr = 1'b0;
    $display("txn %s op=%0d a=%h b=%h cond=%0d out=%h flags=%b", tag, op, a, b, cc,
             bus.alu_out, bus.flags);
  endtask

  initial begin
    checks = 0; failures = 0; model_flags = 4'b0000;
    clr = 1'b1;
    bus.alu_op = 4'd0; bus.alu_a = 0; bus.alu_b = 0; bus.s_bit = 0;
    bus.shifter_carry = 0; bus.cond = 4'd14; bus.b_instr = 0; bus.bl_instr = 0;
    bus.pc_in = 0; bus.imm24 = 0;
    repeat (2) @(posedge clk);

    // Reset with s_bit asserted must still clear flags.
    do_txn("reset",   4'd4, 32'hFFFFFFFF, 32'h1, 1, 0, 4'd14, 0, 0, 0, 0, 1);
    check_eq("reset.flags_zero", 32'(bus.flags), 32'h0);
    do_txn("rst_eq",  4'd13, 0, 0, 0, 0, 4'd0,  0, 0, 0, 0, 0);
    do_txn("rst_al",  4'd13, 0, 0, 0, 0, 4'd14, 0, 0, 0, 0, 0);
    do_txn("rst_nv",  4'd13, 0, 0, 0, 0, 4'd15, 0, 0, 0, 0, 0);
    do_txn("rst_ne",  4'd13, 0, 0, 0, 0, 4'd1,  0, 0, 0, 0, 0);

    do_txn("add_co",  4'd4, 32'hFFFFFFFF, 32'h1, 1, 0, 4'd14, 0, 0, 0, 0, 0);
    check_eq("add_co.flags_0110", 32'(bus.flags), 32'h6);
    do_txn("eq_pass", 4'd13, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    do_txn("hi_fail", 4'd13, 0, 0, 0, 0, 4'd8, 0, 0, 0, 0, 0);
    do_txn("adc",     4'd5, 32'd5, 32'd3, 0, 0, 4'd14, 0, 0, 0, 0, 0);
    check_eq("adc.nine", bus.alu_out, 32'd9);
    do_txn("sbc_c1",  4'd6, 32'd5, 32'd3, 0, 0, 4'd14, 0, 0, 0, 0, 0);
    check_eq("sbc_c1.two", bus.alu_out, 32'd2);
    do_txn("clr_c",   4'd4, 32'd1, 32'd1, 1, 0, 4'd14, 0, 0, 0, 0, 0);
    do_txn("sbc_c0",  4'd6, 32'd5, 32'd3, 0, 0, 4'd14, 0, 0, 0, 0, 0);
    check_eq("sbc_c0.one", bus.alu_out, 32'd1);
    do_txn("rsc_c0",  4'd7, 32'd3, 32'd5, 0, 0, 4'd14, 0, 0, 0, 0, 0);
    do_txn("cmp77",   4'd10, 32'd7, 32'd7, 0, 0, 4'd14, 0, 0, 0, 0, 0);
    check_eq("cmp77.no_write", 32'(bus.no_write), 32'h1);

    do_txn("sub_ovf", 4'd2, 32'h80000000, 32'h1, 1, 0, 4'd14, 0, 0, 0, 0, 0);
    check_eq("sub_ovf.flags_0011", 32'(bus.flags), 32'h3);
    do_txn("ge_fail", 4'd13, 0, 0, 0, 0, 4'd10, 0, 0, 0, 0, 0);
    do_txn("mov_sc",  4'd13, 32'h0, 32'h0, 1, 1, 4'd14, 0, 0, 0, 0, 0);
    check_eq("mov_sc.flags_0111", 32'(bus.flags), 32'h7);

    do_txn("tgt_neg", 4'd13, 0, 0, 0, 0, 4'd14, 0, 0, 32'h100, 24'hFFFFFE, 0);
    check_eq("tgt_neg.f8", bus.branch_target, 32'hF8);
    do_txn("tgt_wrap", 4'd13, 0, 0, 0, 0, 4'd14, 0, 0, 32'h0, 24'hFFFFFF, 0);
    check_eq("tgt_wrap.fffffffc", bus.branch_target, 32'hFFFFFFFC);
    do_txn("b_ne",    4'd13, 0, 0, 0, 0, 4'd1, 1, 0, 32'h200, 24'h10, 0);
    do_txn("bl_eq",   4'd13, 0, 0, 0, 0, 4'd0, 0, 1, 32'h200, 24'h10, 0);
    check_eq("bl_eq.taken", 32'(bus.link_write), 32'h1);
    do_txn("s_nv",    4'd4, 32'h80000000, 32'h80000000, 1, 0, 4'd15, 0, 0, 0, 0, 0);
    check_eq("s_nv.held", 32'(bus.flags), 32'h7);
    do_txn("clr_mid", 4'd15, 32'h0, 32'h0, 1, 1, 4'd14, 0, 0, 0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      do_txn($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), $urandom, $urandom,
             1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
             1'($urandom), $urandom, 24'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
